// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive port
package uart_rx_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam logic [1:0] UART_ADDR_DATA   = 2'b00;
    localparam logic [1:0] UART_ADDR_STATUS = 2'b10;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;

    localparam int OVERSAMPLE = 16;

    // Clock cycles per oversample tick, rounded to nearest and never below one.
    function automatic int calc_tick_div(input int clock_hz, input int baud);
        int div;
        div = (clock_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte FIFO holding received characters until the CPU pops them
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A push into a full FIFO is only taken when a pop frees the head slot on the same edge.
    assign w_do_push = push & (~full | pop);
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_port.sv
// rtl/uart_rx_port.sv - memory-mapped 8N1 UART receiver with byte FIFO and status register
import uart_rx_pkg::*;

module uart_rx_port #(
    parameter int CLOCK_HZ   = 23000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        iCpuClock,
    input  logic        iCpuResetN,
    input  logic        iUartRx,
    input  logic        iUartCtrl,
    input  logic        iIoRead,
    input  logic [1:0]  iAddress,
    output logic [15:0] oUartData,
    output logic        oRxNotEmpty
);

    localparam int TICK_DIV = calc_tick_div(CLOCK_HZ, BAUD);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] OVS_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] OVS_MID  = 4'(OVERSAMPLE / 2 - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [TW-1:0] r_tick_cnt;
    rx_state_t     r_state;
    logic [3:0]    r_ovs;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_armed;
    logic          r_overrun;
    logic          r_frame_err;

    logic          w_rx_s;
    logic          w_tick;
    logic          w_stop_edge;
    logic          w_push;
    logic          w_frame_err_set;
    logic          w_overrun_set;
    logic          w_data_rd;
    logic          w_status_rd;
    logic [7:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;

    assign w_rx_s = r_sync2;
    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge iCpuClock or negedge iCpuResetN) begin
        if (!iCpuResetN) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_tick_cnt <= '0;
        end else begin
            r_sync1    <= iUartRx;
            r_sync2    <= r_sync1;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
        end
    end

    // r_armed drops after a bad stop bit so a held-low break cannot look like a stream of start bits.
    always_ff @(posedge iCpuClock or negedge iCpuResetN) begin
        if (!iCpuResetN) begin
            r_state <= IDLE;
            r_ovs   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_armed <= 1'b0;
        end else if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (w_rx_s) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state <= START;
                        r_ovs   <= '0;
                    end
                end
                START: begin
                    if (r_ovs == OVS_MID) begin
                        if (w_rx_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= DATA;
                            r_ovs   <= '0;
                            r_bit   <= '0;
                        end
                    end else begin
                        r_ovs <= r_ovs + 4'd1;
                    end
                end
                DATA: begin
                    if (r_ovs == OVS_LAST) begin
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        r_ovs   <= '0;
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_ovs <= r_ovs + 4'd1;
                    end
                end
                STOP: begin
                    if (r_ovs == OVS_LAST) begin
                        r_state <= IDLE;
                        r_ovs   <= '0;
                        if (!w_rx_s) begin
                            r_armed <= 1'b0;
                        end
                    end else begin
                        r_ovs <= r_ovs + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_stop_edge     = w_tick & (r_state == STOP) & (r_ovs == OVS_LAST);
    assign w_push          = w_stop_edge & w_rx_s;
    assign w_frame_err_set = w_stop_edge & ~w_rx_s;
    assign w_data_rd       = iUartCtrl & iIoRead & (iAddress == UART_ADDR_DATA);
    assign w_status_rd     = iUartCtrl & iIoRead & (iAddress == UART_ADDR_STATUS);
    assign w_overrun_set   = w_push & w_full & ~w_data_rd;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (iCpuClock),
        .rst_n (iCpuResetN),
        .push  (w_push),
        .pop   (w_data_rd),
        .wdata (r_shift),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Sticky error flags clear on a status read, but a new error on that same edge wins.
    always_ff @(posedge iCpuClock or negedge iCpuResetN) begin
        if (!iCpuResetN) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (w_status_rd) begin
                r_overrun <= 1'b0;
            end
            if (w_frame_err_set) begin
                r_frame_err <= 1'b1;
            end else if (w_status_rd) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign oRxNotEmpty = (w_count != '0);

    always_comb begin
        oUartData = 16'h0000;
        if (w_data_rd && !w_empty) begin
            oUartData = {8'h00, w_head};
        end else if (w_status_rd) begin
            oUartData[ST_NOT_EMPTY] = oRxNotEmpty;
            oUartData[ST_FULL]      = w_full;
            oUartData[ST_OVERRUN]   = r_overrun;
            oUartData[ST_FRAME_ERR] = r_frame_err;
        end
    end

endmodule

// File: doc/uart_rx_port.md
Name: uart_rx_port

Overview:
Memory-mapped UART receive port sitting between the FPGA UART RX pin and the CPU's IO read path; its 16-bit read data is muxed into ioread_data when UartCtrl is asserted.
- Deserialises 8N1 frames with 16x oversampling.
- Buffers received bytes in a FIFO.
- Lets the CPU pop bytes (lw from the data address) and poll status (lw from the status address) in the single-cycle CPU's IO read cycle.
- Runs entirely on the CPU clock.

Parameters:
CLOCK_HZ, 23000000, frequency of iCpuClock in Hz
BAUD, 9600, line rate
FIFO_DEPTH, 16, byte entries; power of two, >= 2
TICK_DIV, CLOCK_HZ/(BAUD*16) rounded to nearest, clock cycles per oversample tick (derived localparam, >= 1)

Ports:
iCpuClock  in  1  CPU clock; all state on rising edge
iCpuResetN  in  1  asynchronous, active-low reset
iUartRx  in  1  serial line from PC, idle high, asynchronous to iCpuClock
iUartCtrl  in  1  chip select from MemOrIO address decode
iIoRead  in  1  IO read strobe from controller
iAddress  in  2  addr_in[1:0]; 2'b00 = DATA, 2'b10 = STATUS, other values read as 16'h0000
oUartData  out  16  combinational read data to ioread_data mux
oRxNotEmpty  out  1  FIFO holds at least one byte (registered)

Behaviour:
- Reset (iCpuResetN low, asynchronous):
  - sync flops = 1; FSM = IDLE.
  - tick counter, bit counter, shift register, FIFO pointers and count = 0.
  - overrun and frame_err sticky flags = 0; oRxNotEmpty = 0.
  - oUartData then reads 16'h0000 for DATA and STATUS.
- Input sync: two-flop synchroniser on iUartRx; the FSM uses only the second-stage value rx_s.
- Tick: free-running counter 0..TICK_DIV-1; tick = 1 for one cycle when the counter wraps.
- FSM (state transitions and sampling happen only on tick cycles):
  - IDLE: armed only after rx_s has been seen high since the last frame. If armed and rx_s == 0: go to START, ovs = 0.
  - START: on ovs == 7, sample. If rx_s == 1 it is a glitch: go to IDLE, no flags change. Otherwise go to DATA, ovs = 0, bit = 0.
  - DATA: on ovs == 15, shift rx_s into the shift register LSB-first and increment bit. After bit 7 go to STOP.
  - STOP: on ovs == 15, sample and go to IDLE.
    - rx_s == 1: push the byte. If the FIFO is full and no pop occurs this cycle, drop the byte and set overrun.
    - rx_s == 0: discard the byte, set frame_err, and disarm until the line is seen high (break-safe).
- DATA read (iUartCtrl & iIoRead & iAddress == 2'b00):
  - oUartData = {8'h00, head byte} combinationally, or 16'h0000 if empty.
  - Pop at the same rising edge if not empty.
  - An empty read neither pops nor changes pointers.
- STATUS read (iUartCtrl & iIoRead & iAddress == 2'b10):
  - oUartData = {12'h000, frame_err, overrun, full, not_empty}, bits 3..0.
  - overrun and frame_err clear at that edge, unless a new error sets the same flag in the same cycle; set wins.
- Simultaneous push and pop:
  - Both are performed and count is unchanged.
  - Push while full with a concurrent pop is accepted, no overrun.
- Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits wide.
  - full = (count == FIFO_DEPTH); not_empty = (count != 0).
- Latency: a byte becomes visible (oRxNotEmpty = 1) on the cycle after the stop-bit sample edge.
- A reset mid-frame abandons the frame. After release, the FSM starts in IDLE unarmed and waits for the line to go high.
- iIoRead without iUartCtrl has no side effects.

Decomposition:
- Package uart_rx_pkg:
  - state enum {IDLE, START, DATA, STOP};
  - address constants UART_ADDR_DATA = 2'b00, UART_ADDR_STATUS = 2'b10;
  - status bit indices ST_NOT_EMPTY = 0, ST_FULL = 1, ST_OVERRUN = 2, ST_FRAME_ERR = 3;
  - OVERSAMPLE = 16.
- One sub-module, uart_rx_fifo: synchronous FIFO, parameter DEPTH, width 8.
  - Ports: push, pop, wdata, head, full, empty, count.
  - Same clock and reset as the parent.

Test Plan:
- Bench setup: CLOCK_HZ = 1536000, BAUD = 9600, giving TICK_DIV = 10.
- Send 0x5A as a valid frame -> STATUS read returns 16'h0001; DATA read returns 16'h005A; next STATUS returns 16'h0000 and oRxNotEmpty = 0.
- Send 17 bytes 0x00..0x10 with no reads -> STATUS returns 16'h0007 (not_empty, full, overrun). The next STATUS returns 16'h0003. Sixteen DATA reads return 0x00..0x0F in order; a 17th DATA read returns 16'h0000.
- Drive a 40-cycle low pulse on idle iUartRx (shorter than half a bit, 80 cycles) -> no push; STATUS stays 16'h0000.
- Send 0xA5 with stop bit 0, then hold the line low for 2 frame times -> STATUS returns 16'h0008, FIFO empty, no further frames. Release the line and send 0x3C -> DATA read returns 16'h003C.
- Fill the FIFO to 16, then issue a DATA read on the same edge as the next stop-bit sample -> byte accepted; STATUS returns 16'h0003 with no overrun bit; count stays 16.
- Assert iCpuResetN low mid-DATA-bit 4 of a frame -> all outputs 0 immediately. After release the tail of the frame produces no push. The next clean frame 0x81 is received correctly.
